// File: rtl/serial_frame_scheduler_if.sv
// Request/grant and serial-output bundle of the frame scheduler.
// master = requester/observer side, slave = scheduler side.
interface serial_frame_scheduler_if;
    logic       iENABLE;
    logic [1:0] iREQ;
    logic [7:0] iDATA0;
    logic [7:0] iDATA1;
    logic [1:0] oGNT;
    logic [2:0] oSEL;
    logic       oSER;
    logic       oBIT_STB;
    logic       oBUSY;
    logic [1:0] oDONE;

    modport master (
        output iENABLE, iREQ, iDATA0, iDATA1,
        input  oGNT, oSEL, oSER, oBIT_STB, oBUSY, oDONE
    );

    modport slave (
        input  iENABLE, iREQ, iDATA0, iDATA1,
        output oGNT, oSEL, oSER, oBIT_STB, oBUSY, oDONE
    );
endinterface

// File: rtl/serial_frame_scheduler.sv
// Two-requester round-robin scheduler that serializes a captured byte
// through an 8-to-1 mux select, one bit per RATE enabled clocks.
module serial_frame_scheduler #(
    parameter int RATE      = 50000000,
    parameter int GAP_BITS  = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                     iCLK,
    input logic                     iCLEAR,
    serial_frame_scheduler_if.slave bus
);
    localparam int PW = $clog2(RATE);
    localparam logic [PW-1:0] PLAST = PW'(RATE - 1);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GLAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0] SEL0 = MSB_FIRST ? 3'd7 : 3'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre, pre_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [2:0]    sel, sel_nx;
    logic [GW-1:0] gap, gap_nx;
    logic [7:0]    shadow, shadow_nx;
    logic [1:0]    gnt, gnt_nx;
    logic [1:0]    done, done_nx;
    logic          stb, stb_nx;
    logic          last, last_nx;
    logic          tick;
    logic          pick1;

    assign tick  = (pre == PLAST) & bus.iENABLE;
    // last==1 means requester 1 was served most recently
    assign pick1 = bus.iREQ[1] & (~bus.iREQ[0] | ~last);

    always_comb begin
        state_nx  = state;
        pre_nx    = pre;
        bit_nx    = bit_cnt;
        sel_nx    = sel;
        gap_nx    = gap;
        shadow_nx = shadow;
        gnt_nx    = gnt;
        done_nx   = 2'b00;
        stb_nx    = 1'b0;
        last_nx   = last;
        if (tick)
            pre_nx = '0;
        else if (bus.iENABLE)
            pre_nx = pre + PW'(1);
        unique case (state)
            IDLE: begin
                if (bus.iENABLE && bus.iREQ != 2'b00) begin
                    shadow_nx = pick1 ? bus.iDATA1 : bus.iDATA0;
                    gnt_nx    = pick1 ? 2'b10 : 2'b01;
                    last_nx   = pick1;
                    sel_nx    = SEL0;
                    bit_nx    = 3'd0;
                    stb_nx    = 1'b1;
                    pre_nx    = '0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt != 3'd7) begin
                        sel_nx = MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
                        bit_nx = bit_cnt + 3'd1;
                        stb_nx = 1'b1;
                    end else begin
                        done_nx  = gnt;
                        gnt_nx   = 2'b00;
                        gap_nx   = '0;
                        state_nx = (GAP_BITS == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap == GLAST)
                        state_nx = IDLE;
                    else
                        gap_nx = gap + GW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iCLEAR) begin
        if (!iCLEAR) begin
            state   <= IDLE;
            pre     <= '0;
            bit_cnt <= 3'd0;
            sel     <= 3'd0;
            gap     <= '0;
            shadow  <= 8'h00;
            gnt     <= 2'b00;
            done    <= 2'b00;
            stb     <= 1'b0;
            last    <= 1'b1;
        end else begin
            state   <= state_nx;
            pre     <= pre_nx;
            bit_cnt <= bit_nx;
            sel     <= sel_nx;
            gap     <= gap_nx;
            shadow  <= shadow_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
            stb     <= stb_nx;
            last    <= last_nx;
        end
    end

    assign bus.oGNT     = gnt;
    assign bus.oSEL     = sel;
    assign bus.oSER     = (state == SHIFT) ? shadow[sel] : 1'b0;
    assign bus.oBIT_STB = stb;
    assign bus.oBUSY    = (state != IDLE);
    assign bus.oDONE    = done;
endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Bench for serial_frame_scheduler: directed scenarios plus random frames
// checked cycle by cycle against a frame-level timing model.
module tb_serial_frame_scheduler;
    localparam int RATE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] req;
    logic [7:0] d0, d1;
    bit         cur;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         last_g [2];
    int         gnt_cyc, done_cyc;

    logic [1:0] o_gnt, o_done;
    logic [2:0] o_sel;
    logic       o_ser, o_stb, o_busy;

    serial_frame_scheduler_if ia ();
    serial_frame_scheduler_if ib ();

    assign ia.iENABLE = en;
    assign ia.iREQ    = cur ? 2'b00 : req;
    assign ia.iDATA0  = d0;
    assign ia.iDATA1  = d1;
    assign ib.iENABLE = en;
    assign ib.iREQ    = cur ? req : 2'b00;
    assign ib.iDATA0  = d0;
    assign ib.iDATA1  = d1;

    serial_frame_scheduler #(.RATE(RATE), .GAP_BITS(1), .MSB_FIRST(1'b0)) dut_a (
        .iCLK(clk), .iCLEAR(rst_n), .bus(ia.slave));
    serial_frame_scheduler #(.RATE(RATE), .GAP_BITS(0), .MSB_FIRST(1'b1)) dut_b (
        .iCLK(clk), .iCLEAR(rst_n), .bus(ib.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        o_gnt  = cur ? ib.oGNT : ia.oGNT;
        o_sel  = cur ? ib.oSEL : ia.oSEL;
        o_ser  = cur ? ib.oSER : ia.oSER;
        o_stb  = cur ? ib.oBIT_STB : ia.oBIT_STB;
        o_busy = cur ? ib.oBUSY : ia.oBUSY;
        o_done = cur ? ib.oDONE : ia.oDONE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] idx(input int b);
        return cur ? 3'(7 - b) : 3'(b);
    endfunction

    // Round-robin rule: a lone request wins; a tie goes to the one not served last.
    function automatic logic [1:0] arb(input logic [1:0] r);
        logic [1:0] g;
        if (r == 2'b11)
            g = last_g[cur] ? 2'b01 : 2'b10;
        else
            g = r;
        last_g[cur] = (g == 2'b10);
        return g;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_gnt"}, o_gnt, 0);
        check({tag, "_sel"}, o_sel, 0);
        check({tag, "_ser"}, o_ser, 0);
        check({tag, "_stb"}, o_stb, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
    endtask

    // One frame: grant at the next edge, then each bit held RATE enabled cycles.
    task automatic frame(input logic [1:0] g, input logic [7:0] w, input int drop_at,
                         input int drop_len, input bit drop_req);
        int n, off, stbs, gap_bits, fin;
        bit did, ep;
        logic [2:0] ix;
        gap_bits = cur ? 0 : 1;
        fin = (8 + gap_bits) * RATE;
        @(posedge clk);
        @(negedge clk);
        gnt_cyc = cyc;
        check("grant", o_gnt, g);
        check("grant_busy", o_busy, 1);
        check("grant_stb", o_stb, 1);
        check("grant_sel", o_sel, idx(0));
        check("grant_ser", o_ser, w[idx(0)]);
        check("grant_done", o_done, 0);
        stbs = 1;
        n = 0;
        off = 0;
        did = 0;
        if (drop_req) begin
            req = 2'b00;
            d0 = ~d0;
            d1 = ~d1;
        end
        for (int k = 0; k < 200 && n < fin; k++) begin
            if (drop_len > 0 && n == drop_at && !did) begin
                did = 1;
                off = drop_len;
            end
            en = (off == 0);
            if (off > 0) off--;
            ep = en;
            @(posedge clk);
            if (ep) n++;
            @(negedge clk);
            if (o_stb === 1'b1) stbs++;
            if (n < 8 * RATE) begin
                ix = idx(n / RATE);
                check("bit_gnt", o_gnt, g);
                check("bit_sel", o_sel, ix);
                check("bit_ser", o_ser, w[ix]);
                check("bit_stb", o_stb, (ep && n % RATE == 0) ? 1 : 0);
                check("bit_busy", o_busy, 1);
                check("bit_done", o_done, 0);
            end else begin
                if (n == 8 * RATE) done_cyc = cyc;
                check("end_gnt", o_gnt, 0);
                check("end_sel", o_sel, idx(7));
                check("end_ser", o_ser, 0);
                check("end_stb", o_stb, 0);
                check("end_done", o_done, (n == 8 * RATE) ? g : 2'b00);
                check("end_busy", o_busy, (n < fin) ? 1 : 0);
            end
        end
        en = 1'b1;
        check("frame_finished", (n >= fin) ? 1 : 0, 1);
        check("stb_count", stbs, 8);
        check("frame_len", done_cyc - gnt_cyc, 8 * RATE + (did ? drop_len : 0));
    endtask

    initial begin
        logic [1:0] g;
        int prev_done;
        rst_n = 1'b0;
        en = 1'b1;
        req = 2'b00;
        d0 = 8'h00;
        d1 = 8'h00;
        cur = 1'b0;
        last_g[0] = 1'b1;
        last_g[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Tie held high: alternating grants with an enforced gap between them.
        req = 2'b11;
        d0 = 8'h0F;
        d1 = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            g = arb(req);
            check("rr_order", g, (i % 2 == 0) ? 2'b01 : 2'b10);
            frame(g, (g == 2'b10) ? 8'hF0 : 8'h0F, 0, 0, 1'b0);
            if (i > 0)
                check("done_to_gnt", (gnt_cyc - prev_done >= 4) ? 1 : 0, 1);
            prev_done = done_cyc;
        end
        req = 2'b00;
        @(negedge clk);
        check("idle_after_rr", o_busy, 0);

        req = 2'b01;
        d0 = 8'hA5;
        frame(arb(req), 8'hA5, 0, 0, 1'b0);
        req = 2'b00;

        req = 2'b01;
        frame(arb(req), 8'hA5, 3 * RATE + 1, 10, 1'b0);
        req = 2'b00;

        req = 2'b01;
        d0 = 8'h3C;
        frame(arb(req), 8'h3C, 0, 0, 1'b1);
        req = 2'b00;
        @(negedge clk);

        cur = 1'b1;
        req = 2'b10;
        d1 = 8'h81;
        frame(arb(req), 8'h81, 0, 0, 1'b0);
        req = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] w;
            int da, dl;
            cur = 1'($urandom_range(0, 1));
            req = 2'($urandom_range(1, 3));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            da = $urandom_range(1, 8 * RATE - 1);
            dl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
            g = arb(req);
            w = (g == 2'b10) ? d1 : d0;
            frame(g, w, da, dl, 1'($urandom_range(0, 1)));
            req = 2'b00;
            @(negedge clk);
        end

        // Asynchronous clear between edges in the middle of a frame.
        cur = 1'b0;
        req = 2'b11;
        d0 = 8'hFF;
        d1 = 8'hFF;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("pre_clear_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        last_g[0] = 1'b1;
        last_g[1] = 1'b1;
        g = arb(req);
        check("post_clear_arb", g, 2'b01);
        frame(g, 8'hFF, 0, 0, 1'b0);
        req = 2'b00;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_frame_scheduler.md
Name: serial_frame_scheduler

Overview:
- Arbitrates between two requesters that each present an 8-bit word.
- Sequences the 3-bit bit-select that drives the 8-to-1 serializing mux, paced by an internal frequency-divider tick.
- Owns the word shadow register, the bit index and the inter-frame gap.
- Sits between the user-input logic and the serial output and LED select lines. It replaces the free-running divider and ripple counter with a controlled, handshaked sequencer.

Parameters:
RATE, 50000000, iCLK cycles per bit period (min 2)
GAP_BITS, 1, idle bit periods inserted after each frame (0 allowed)
MSB_FIRST, 0, 0 = send bit 0 first (oSEL counts up); 1 = send bit 7 first (oSEL counts down)

Ports:
iCLK  input  1  system clock, all state on rising edge
iCLEAR  input  1  asynchronous active-low reset
iENABLE  input  1  1 = prescaler runs and grants are allowed; 0 = freeze
iREQ  input  2  request per requester, level-sensitive
iDATA0  input  8  word from requester 0
iDATA1  input  8  word from requester 1
oGNT  output  2  one-hot grant, held for the whole SHIFT phase
oSEL  output  3  mux bit-select index
oSER  output  1  serialized bit: shadow[oSEL] in SHIFT, 0 otherwise
oBIT_STB  output  1  one-cycle pulse when a new bit is presented
oBUSY  output  1  1 whenever state != IDLE
oDONE  output  2  one-cycle pulse to the served requester at frame end

Behaviour:
Reset:
- On iCLEAR=0, immediately, including mid-frame: state=IDLE, prescaler=0, bit count=0, oSEL=0, oGNT=0, oBIT_STB=0, oDONE=0, oBUSY=0, oSER=0.
- Round-robin pointer is reset to "last granted = 1", so requester 0 wins the first tie.

Prescaler:
- Counts 0..RATE-1 and only advances when iENABLE=1.
- tick = (count==RATE-1) & iENABLE; count wraps to 0 on tick.
- Forced to 0 on the grant edge.

State IDLE:
- Acts only when iENABLE=1 and iREQ!=0.
- Single request: grant it. Both requesting: grant the requester not last granted, then update the pointer.
- Grant edge E0: shadow <= selected iDATA; oGNT <= one-hot; oSEL <= 0 (MSB_FIRST=0) or 7; bit count=0; oBIT_STB=1 for one cycle; state=SHIFT.

State SHIFT:
- Each bit is held exactly RATE enabled cycles.
- On tick with bit count<7: oSEL steps (+1, or -1 when MSB_FIRST=1), count+1, oBIT_STB pulses.
- On tick with count==7: oDONE[g]=1 for one cycle, oGNT=0; go to GAP, or to IDLE if GAP_BITS=0.
- With iENABLE=1 throughout, the done edge is E0+8*RATE.

State GAP:
- oSER=0; oSEL keeps its last value.
- Counts GAP_BITS ticks, then goes to IDLE.
- The earliest next grant is the edge after IDLE is entered.

Boundary rules:
- iDATA changes after grant are ignored (shadow register).
- iREQ deasserted mid-frame: the frame still completes and oDONE still pulses.
- iREQ still high after oDONE: treated as a new request and re-arbitrated.
- iENABLE=0: prescaler, oSEL, bit count and gap count all hold; no grant in IDLE; oSER stays valid.
- oDONE and a new oGNT are never asserted in the same cycle.
- oGNT is never 2'b11.
- oSEL is registered and glitch-free.
- oSER is a combinational mux of registered signals.

Test Plan:
1. RATE=4, GAP_BITS=1, MSB_FIRST=0. iREQ=01, iDATA0=8'hA5 -> oGNT=01 at E0; oSER sequence 1,0,1,0,0,1,0,1, each held 4 cycles; oSEL 0..7; 8 oBIT_STB pulses; oDONE=01 at E0+32; oBUSY low at E0+36.
2. iREQ=11 held, iDATA0=8'h0F, iDATA1=8'hF0 -> frames granted 0,1,0,1 in order; every oDONE precedes the next oGNT by ≥ 4 cycles.
3. MSB_FIRST=1, iDATA1=8'h81, iREQ=10 -> oSEL 7 down to 0; oSER 1,0,0,0,0,0,0,1.
4. Mid-frame, drop iENABLE for 10 cycles at bit 3 -> oSEL stays 3 and oSER is stable; the frame ends 10 cycles later than in scenario 1; no extra oBIT_STB.
5. Change iDATA0 and drop iREQ right after grant -> oSER still matches the captured word; oDONE still pulses.
6. Pulse iCLEAR low mid-SHIFT, between clock edges -> all outputs 0 immediately; after release, the first grant goes to requester 0 when both request.
